word_serializer: RTL and testbench

Parallel-to-serial stage directly downstream of the bit reverser. It accepts one 2**N-bit word (the reverser's output) through a valid/ready handshake and shifts it out one bit at a time, MSB first, under a bit-rate strobe. Bit order on the line is set upstream: reverser s=0 gives MSB-first, s=1 gives effective LSB-first. A counter-driven FSM frames each word with a last-bit flag.

---
 rtl/word_serializer_if.sv | 26 ++
 rtl/word_serializer.sv | 160 ++++++++++++++++
 tb/tb_word_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/word_serializer_if.sv
// Handshake and serial-line bundle for word_serializer.
// The master side is the upstream word source and bit-rate strobe; the slave side is the serializer.
interface word_serializer_if #(
    parameter int N = 3
);
    localparam int W = 2 ** N;

    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         shift_en;
    logic         sout;
    logic         sout_valid;
    logic         sout_last;
    logic         busy;

    modport master (
        output din, din_valid, shift_en,
        input  din_ready, sout, sout_valid, sout_last, busy
    );

    modport slave (
        input  din, din_valid, shift_en,
        output din_ready, sout, sout_valid, sout_last, busy
    );
endinterface

// File: rtl/word_serializer.sv
// Parallel-to-serial stage: loads one 2**N-bit word and shifts it out MSB first on shift_en.
// Optional macro WORD_SERIALIZER_PARITY_EN appends an even-parity bit as a final bit slot.
module word_serializer #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                reset,
    word_serializer_if.slave    bus
);
    localparam int W = 2 ** N;
    localparam logic [N-1:0] CNT_LAST = {N{1'b1}};
    localparam logic [N-1:0] CNT_ONE  = {{(N-1){1'b0}}, 1'b1};

`ifdef WORD_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
    } state_t;
`endif

    state_t         state_r;
    state_t         state_s;
    logic [W-1:0]   shreg_r;
    logic [N-1:0]   cnt_r;
    logic           load_s;
    logic           shift_s;
    logic           sout_s;
    logic           sout_valid_s;
    logic           sout_last_s;

`ifdef WORD_SERIALIZER_PARITY_EN
    logic           par_r;

    function automatic logic even_parity(input logic [W-1:0] d);
        return ^d;
    endfunction
`endif

    // Next-state and datapath-enable decode
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.din_valid) begin
                    load_s  = 1'b1;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.shift_en) begin
                    shift_s = 1'b1;
                    if (cnt_r == CNT_LAST) begin
`ifdef WORD_SERIALIZER_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_IDLE;
`endif
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (bus.shift_en) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, shift register and bit counter; the counter wraps to 0 as SHIFT is left
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            shreg_r <= {W{1'b0}};
            cnt_r   <= {N{1'b0}};
        end else begin
            state_r <= state_s;
            if (load_s) begin
                shreg_r <= bus.din;
                cnt_r   <= {N{1'b0}};
            end else if (shift_s) begin
                shreg_r <= {shreg_r[W-2:0], 1'b0};
                cnt_r   <= cnt_r + CNT_ONE;
            end else begin
                shreg_r <= shreg_r;
                cnt_r   <= cnt_r;
            end
        end
    end

`ifdef WORD_SERIALIZER_PARITY_EN
    // Parity of the accepted word, held until its parity slot is sent
    always_ff @(posedge clk) begin
        if (reset) begin
            par_r <= 1'b0;
        end else if (load_s) begin
            par_r <= even_parity(bus.din);
        end else begin
            par_r <= par_r;
        end
    end
`endif

    // Serial-line decode from the state register and shift register
    always_comb begin
        sout_s       = 1'b0;
        sout_valid_s = 1'b0;
        sout_last_s  = 1'b0;
        case (state_r)
            ST_SHIFT: begin
                sout_s       = shreg_r[W-1];
                sout_valid_s = 1'b1;
`ifdef WORD_SERIALIZER_PARITY_EN
                sout_last_s  = 1'b0;
`else
                sout_last_s  = (cnt_r == CNT_LAST);
`endif
            end
`ifdef WORD_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                sout_s       = par_r;
                sout_valid_s = 1'b1;
                sout_last_s  = 1'b1;
            end
`endif
            default: begin
                sout_s       = 1'b0;
                sout_valid_s = 1'b0;
                sout_last_s  = 1'b0;
            end
        endcase
    end

    assign bus.din_ready  = (state_r == ST_IDLE);
    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.sout       = sout_s;
    assign bus.sout_valid = sout_valid_s;
    assign bus.sout_last  = sout_last_s;

endmodule

// File: tb/tb_word_serializer.sv
// Randomized and directed bench for word_serializer, checked against a bit-queue model.
module tb_word_serializer;
    localparam int N = 3;
    localparam int W = 2 ** N;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   dut_hs;
    bit   model_q[$];

    word_serializer_if #(.N(N)) bus ();

    word_serializer #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs against the model, advance the model.
    task automatic cycle(input string tag, input logic r, input logic dv,
                         input logic [W-1:0] d, input logic se);
        logic [4:0] exp_v;
        logic [4:0] obs_v;
        bit         idle;
        reset         = r;
        bus.din_valid = dv;
        bus.din       = d;
        bus.shift_en  = se;
        @(negedge clk);
        idle  = (model_q.size() == 0);
        exp_v = {idle, !idle, !idle, idle ? 1'b0 : model_q[0], model_q.size() == 1};
        obs_v = {bus.din_ready, bus.busy, bus.sout_valid, bus.sout, bus.sout_last};
        check_eq(tag, {27'd0, obs_v}, {27'd0, exp_v});
        if (!r && dv && bus.din_ready) dut_hs++;
        if (r) begin
            model_q.delete();
        end else if (idle) begin
            if (dv) begin
                for (int i = W - 1; i >= 0; i--) model_q.push_back(d[i]);
`ifdef WORD_SERIALIZER_PARITY_EN
                model_q.push_back(^d);
`endif
            end
        end else if (se) begin
            void'(model_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        dut_hs = 0;
        reset = 1'b1;
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.shift_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_q.delete();

        // Reset state
        cycle("reset", 1'b1, 1'b1, 8'hFF, 1'b1);
        cycle("after_reset", 1'b0, 1'b0, 8'h00, 1'b1);

        // F0 with one-cycle valid, shift_en high
        cycle("f0_load", 1'b0, 1'b1, 8'hF0, 1'b1);
        for (int i = 0; i < W + 2; i++) cycle("f0_shift", 1'b0, 1'b0, 8'h55, 1'b1);

        // Reversed word 0F
        cycle("0f_load", 1'b0, 1'b1, 8'h0F, 1'b1);
        for (int i = 0; i < W + 2; i++) cycle("0f_shift", 1'b0, 1'b0, 8'h00, 1'b1);

        // A5 with toggling strobe
        cycle("a5_load", 1'b0, 1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 2 * W + 4; i++) cycle("a5_toggle", 1'b0, 1'b0, 8'h00, (i % 2) == 0);

        // Back-to-back with din_valid held high
        dut_hs = 0;
        for (int i = 0; i < 2 * (W + 2); i++)
            cycle("b2b", 1'b0, dut_hs < 2, (dut_hs == 0) ? 8'h81 : 8'h7E, 1'b1);
        check_eq("b2b_handshakes", dut_hs, 32'd2);

        // Reset after third bit, then a fresh word
        cycle("mid_load", 1'b0, 1'b1, 8'hF0, 1'b1);
        for (int i = 0; i < 3; i++) cycle("mid_shift", 1'b0, 1'b0, 8'h00, 1'b1);
        cycle("mid_reset", 1'b1, 1'b1, 8'hFF, 1'b1);
        cycle("mid_idle", 1'b0, 1'b0, 8'h00, 1'b1);
        cycle("3c_load", 1'b0, 1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < W + 2; i++) cycle("3c_shift", 1'b0, 1'b0, 8'h00, 1'b1);

        // Parity-sensitive words (also valid without the parity slot)
        cycle("07_load", 1'b0, 1'b1, 8'h07, 1'b1);
        for (int i = 0; i < W + 2; i++) cycle("07_shift", 1'b0, 1'b0, 8'h00, 1'b1);
        cycle("03_load", 1'b0, 1'b1, 8'h03, 1'b1);
        for (int i = 0; i < W + 2; i++) cycle("03_shift", 1'b0, 1'b0, 8'h00, 1'b1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++)
            cycle("random", $urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
                  8'($urandom), $urandom_range(0, 3) != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
